// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_NICKEL  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;
  localparam logic [1:0] COIN_INVALID = 2'b11;

  // Coin value in nickels; invalid coins are worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] coin_type);
    logic [2:0] val;
    case (coin_type)
      COIN_NICKEL:  val = 3'd1;
      COIN_DIME:    val = 3'd2;
      COIN_QUARTER: val = 3'd5;
      default:      val = 3'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down/load counter with enable holding the credit in nickels.
module credit_counter #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up) count <= count + 1'b1;
      else    count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit controller: takes coins, vends at PRICE and pays change one nickel
// per cycle by stepping a shared credit counter.
//
// state  | meaning
// IDLE   | waiting for coin / select / return, coin_ready high
// ADD    | counting credit up one nickel per cycle for an accepted coin
// VEND   | counting PRICE down, dispense on the last step
// CHANGE | paying out remaining credit one nickel per cycle
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int BITS       = 4,
  parameter int PRICE      = 7,
  parameter int MAX_CREDIT = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            coin_valid,
  input  logic [1:0]      coin_type,
  output logic            coin_ready,
  output logic            coin_reject,
  input  logic            select,
  input  logic            return_req,
  output logic            deny,
  output logic            dispense,
  output logic            nickel_out,
  output logic [BITS-1:0] credit,
  output logic            busy
);

  localparam logic [BITS-1:0] PRICE_C = BITS'(PRICE);
  localparam logic [BITS-1:0] ONE_C   = BITS'(1);
  localparam logic [BITS+2:0] MAX_C   = (BITS+3)'(MAX_CREDIT);

  vend_state_e     state, state_d;
  logic [BITS-1:0] remaining, remaining_d;
  logic            reject_d, deny_d;
  logic            cnt_en, cnt_up;
  logic [2:0]      coin_val;
  logic [BITS+2:0] coin_sum;

  assign coin_val   = coin_value(coin_type);
  // Widened sum so an over-limit coin is caught instead of wrapping.
  assign coin_sum   = {3'b000, credit} + {{BITS{1'b0}}, coin_val};
  assign coin_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  credit_counter #(.BITS(BITS)) u_credit_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (cnt_en),
    .up       (cnt_up),
    .load     (1'b0),
    .load_val ('0),
    .count    (credit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      remaining   <= '0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
    end else begin
      state       <= state_d;
      remaining   <= remaining_d;
      coin_reject <= reject_d;
      deny        <= deny_d;
    end
  end

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    cnt_en      = 1'b0;
    cnt_up      = 1'b0;
    reject_d    = 1'b0;
    deny_d      = 1'b0;
    dispense    = 1'b0;
    nickel_out  = 1'b0;
    case (state)
      IDLE: begin
        if (coin_valid) begin
          if (coin_type == COIN_INVALID || coin_sum > MAX_C) begin
            reject_d = 1'b1;
          end else begin
            remaining_d = BITS'(coin_val);
            state_d     = ADD;
          end
        end else if (select) begin
          if (credit >= PRICE_C) begin
            remaining_d = PRICE_C;
            state_d     = VEND;
          end else begin
            deny_d = 1'b1;
          end
        end else if (return_req) begin
          if (credit != '0) state_d = CHANGE;
        end
      end
      ADD: begin
        cnt_en      = 1'b1;
        cnt_up      = 1'b1;
        remaining_d = remaining - 1'b1;
        if (remaining == ONE_C) state_d = IDLE;
      end
      VEND: begin
        cnt_en      = 1'b1;
        remaining_d = remaining - 1'b1;
        if (remaining == ONE_C) begin
          dispense = 1'b1;
          state_d  = (credit > ONE_C) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (credit != '0) begin
          cnt_en     = 1'b1;
          nickel_out = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with hand-computed expectations.
module tb_vend_credit_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       coin_reject;
  logic       select;
  logic       return_req;
  logic       deny;
  logic       dispense;
  logic       nickel_out;
  logic [3:0] credit;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int busy_cyc, disp_cnt, nick_cnt, ready_busy, disp_at;

  always #5 clk = ~clk;

  vend_credit_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .coin_ready  (coin_ready),
    .coin_reject (coin_reject),
    .select      (select),
    .return_req  (return_req),
    .deny        (deny),
    .dispense    (dispense),
    .nickel_out  (nickel_out),
    .credit      (credit),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle request; returns at the next negedge, where the DUT has reacted.
  task automatic req(input logic c, input logic [1:0] t, input logic s, input logic r);
    coin_valid = c;
    coin_type  = t;
    select     = s;
    return_req = r;
    @(negedge clk);
    coin_valid = 1'b0;
    coin_type  = 2'b00;
    select     = 1'b0;
    return_req = 1'b0;
  endtask

  task automatic run_idle();
    busy_cyc = 0; disp_cnt = 0; nick_cnt = 0; ready_busy = 0; disp_at = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_cyc++;
      if (dispense) begin disp_cnt++; disp_at = busy_cyc; end
      if (nickel_out) nick_cnt++;
      if (coin_ready) ready_busy++;
      @(negedge clk);
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic add_coin(input logic [1:0] t);
    req(1'b1, t, 1'b0, 1'b0);
    run_idle();
  endtask

  initial begin
    reset_n = 1'b0; coin_valid = 1'b0; coin_type = 2'b00; select = 1'b0; return_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", coin_ready, 1);
    check("rst_pulses", {coin_reject, deny, dispense, nickel_out}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of adding a quarter
    req(1'b1, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("midadd_busy", busy, 1);
    check("midadd_credit", credit, 2);
    reset_n = 1'b0;
    #1;
    check("midadd_rst_credit", credit, 0);
    check("midadd_rst_busy", busy, 0);
    check("midadd_rst_ready", coin_ready, 1);
    check("midadd_rst_pulses", {coin_reject, deny, dispense, nickel_out}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midadd_after_credit", credit, 0);

    // Credit build-up
    add_coin(2'b00);
    check("nickel_busy", busy_cyc, 1);
    check("nickel_ready", ready_busy, 0);
    check("nickel_credit", credit, 1);
    add_coin(2'b01);
    check("dime_busy", busy_cyc, 2);
    check("dime_ready", ready_busy, 0);
    check("dime_credit", credit, 3);
    add_coin(2'b10);
    check("quarter_busy", busy_cyc, 5);
    check("quarter_ready", ready_busy, 0);
    check("quarter_credit", credit, 8);

    // Vend with one nickel of change
    req(1'b0, 2'b00, 1'b1, 1'b0);
    run_idle();
    check("vend8_busy", busy_cyc, 9);
    check("vend8_disp", disp_cnt, 1);
    check("vend8_disp_at", disp_at, 7);
    check("vend8_nickels", nick_cnt, 1);
    check("vend8_credit", credit, 0);

    // Deny at credit 5
    add_coin(2'b10);
    check("c5_credit", credit, 5);
    req(1'b0, 2'b00, 1'b1, 1'b0);
    check("deny_pulse", deny, 1);
    check("deny_busy", busy, 0);
    @(negedge clk);
    check("deny_clear", deny, 0);
    check("deny_credit", credit, 5);

    // Overflow reject at credit 12
    add_coin(2'b10);
    add_coin(2'b01);
    check("c12_credit", credit, 12);
    req(1'b1, 2'b10, 1'b0, 1'b0);
    check("ovf_reject", coin_reject, 1);
    check("ovf_busy", busy, 0);
    @(negedge clk);
    check("ovf_clear", coin_reject, 0);
    check("ovf_credit", credit, 12);

    // Invalid coin
    req(1'b1, 2'b11, 1'b0, 1'b0);
    check("inv_reject", coin_reject, 1);
    @(negedge clk);
    check("inv_clear", coin_reject, 0);
    check("inv_credit", credit, 12);

    // Full return of 12
    req(1'b0, 2'b00, 1'b0, 1'b1);
    run_idle();
    check("ret12_nickels", nick_cnt, 12);
    check("ret12_credit", credit, 0);

    // Priority: coin beats select and return
    add_coin(2'b00);
    add_coin(2'b01);
    check("c3_credit", credit, 3);
    req(1'b1, 2'b01, 1'b1, 1'b1);
    check("prio_deny", deny, 0);
    run_idle();
    check("prio_busy", busy_cyc, 2);
    check("prio_pulses", disp_cnt + nick_cnt, 0);
    check("prio_credit", credit, 5);
    req(1'b0, 2'b00, 1'b0, 1'b1);
    run_idle();
    check("ret5_nickels", nick_cnt, 5);
    check("ret5_busy", busy_cyc, 6);
    check("ret5_credit", credit, 0);

    // Exact price, no change
    add_coin(2'b10);
    add_coin(2'b01);
    check("c7_credit", credit, 7);
    req(1'b0, 2'b00, 1'b1, 1'b0);
    run_idle();
    check("vend7_busy", busy_cyc, 7);
    check("vend7_disp", disp_cnt, 1);
    check("vend7_nickels", nick_cnt, 0);
    check("vend7_credit", credit, 0);

    // Return with nothing to return
    req(1'b0, 2'b00, 1'b0, 1'b1);
    check("ret0_busy", busy, 0);
    check("ret0_nickel", nickel_out, 0);
    @(negedge clk);
    check("ret0_busy2", busy, 0);
    check("ret0_credit", credit, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
